// File: rtl/bwt_params_shadow.sv
// bwt_params_shadow: captures the live seeding parameters on params_update,
// validates them, waits for the SMEM/seeding engine to drain, and then commits
// them atomically into the shadow registers that the engine reads.
// The engine never sees a half-written 40-bit value or a change mid-task.
//
// Build option: define PARAMS_CHECK_EN to enable ordering/range validation of
// the captured set. With the macro undefined, every capture passes, err_cfg
// is tied low and no comparators are built.
module bwt_params_shadow #(
  parameter int IDLE_HOLD = 4,   // consecutive idle cycles required before commit (1..255)
  parameter int CNT_W     = 16   // width of update_cnt
) (
  input  logic             s_axi_aclk,
  input  logic             rst,
  input  logic             params_update,
  input  logic [39:0]      bwt_len,
  input  logic [39:0]      pri_pos,
  input  logic [39:0]      acc_cnt_A,
  input  logic [39:0]      acc_cnt_C,
  input  logic [39:0]      acc_cnt_G,
  input  logic [39:0]      acc_cnt_T,
  input  logic [15:0]      min_mlen,
  input  logic [15:0]      sf_mlen,
  input  logic [15:0]      rs_min_mlen,
  input  logic [39:0]      sf_max_intv,
  input  logic [39:0]      rs_max_intv,
  input  logic             engine_busy,
  output logic             engine_hold,
  output logic [39:0]      shd_bwt_len,
  output logic [39:0]      shd_pri_pos,
  output logic [39:0]      shd_acc_cnt_A,
  output logic [39:0]      shd_acc_cnt_C,
  output logic [39:0]      shd_acc_cnt_G,
  output logic [39:0]      shd_acc_cnt_T,
  output logic [15:0]      shd_min_mlen,
  output logic [15:0]      shd_sf_mlen,
  output logic [15:0]      shd_rs_min_mlen,
  output logic [39:0]      shd_sf_max_intv,
  output logic [39:0]      shd_rs_max_intv,
  output logic             shd_valid,
  output logic             commit_pulse,
  output logic             err_cfg,
  output logic [CNT_W-1:0] update_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One complete parameter set; moved as a unit so a commit is atomic.
  typedef struct packed {
    logic [39:0] bwt_len;
    logic [39:0] pri_pos;
    logic [39:0] acc_cnt_A;
    logic [39:0] acc_cnt_C;
    logic [39:0] acc_cnt_G;
    logic [39:0] acc_cnt_T;
    logic [15:0] min_mlen;
    logic [15:0] sf_mlen;
    logic [15:0] rs_min_mlen;
    logic [39:0] sf_max_intv;
    logic [39:0] rs_max_intv;
  } params_t;

  // Last idle-counter value before the commit edge.
  localparam logic [7:0] HOLD_LAST = 8'(IDLE_HOLD - 1);

  state_t     state_r;
  params_t    live_s;
  params_t    stg_r;
  params_t    shd_r;
  logic [7:0] idle_cnt_r;
  logic       cfg_ok_s;

`ifdef PARAMS_CHECK_EN
  // Counts must be monotonic up to the BWT length, the primary position must
  // lie inside the BWT, and a zero minimum match length is meaningless.
  function automatic logic params_ok(input params_t p);
    logic ok;
    ok = (p.acc_cnt_A <= p.acc_cnt_C) &&
         (p.acc_cnt_C <= p.acc_cnt_G) &&
         (p.acc_cnt_G <= p.acc_cnt_T) &&
         (p.acc_cnt_T <= p.bwt_len)   &&
         (p.pri_pos   <= p.bwt_len)   &&
         (p.min_mlen  != 16'd0);
    return ok;
  endfunction
`endif

  // Gather the live register-block fields into one parameter set.
  always_comb begin
    live_s             = '0;
    live_s.bwt_len     = bwt_len;
    live_s.pri_pos     = pri_pos;
    live_s.acc_cnt_A   = acc_cnt_A;
    live_s.acc_cnt_C   = acc_cnt_C;
    live_s.acc_cnt_G   = acc_cnt_G;
    live_s.acc_cnt_T   = acc_cnt_T;
    live_s.min_mlen    = min_mlen;
    live_s.sf_mlen     = sf_mlen;
    live_s.rs_min_mlen = rs_min_mlen;
    live_s.sf_max_intv = sf_max_intv;
    live_s.rs_max_intv = rs_max_intv;
  end

  // Validation verdict on the staged set, consumed in the CHECK state.
  always_comb begin
`ifdef PARAMS_CHECK_EN
    cfg_ok_s = params_ok(stg_r);
`else
    cfg_ok_s = 1'b1;
`endif
  end

  // Capture / check / drain / commit sequencer with registered outputs.
  always_ff @(posedge s_axi_aclk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      stg_r        <= '0;
      shd_r        <= '0;
      idle_cnt_r   <= 8'd0;
      engine_hold  <= 1'b0;
      shd_valid    <= 1'b0;
      commit_pulse <= 1'b0;
      update_cnt   <= '0;
`ifdef PARAMS_CHECK_EN
      err_cfg      <= 1'b0;
`endif
    end else begin
      commit_pulse <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (params_update) begin
            stg_r   <= live_s;
            state_r <= ST_CHECK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (params_update) begin
            // Latest capture wins; evaluate the new set next cycle.
            stg_r      <= live_s;
            idle_cnt_r <= 8'd0;
            state_r    <= ST_CHECK;
          end else if (cfg_ok_s) begin
            idle_cnt_r  <= 8'd0;
            engine_hold <= 1'b1;
            state_r     <= ST_DRAIN;
          end else begin
`ifdef PARAMS_CHECK_EN
            err_cfg     <= 1'b1;
`endif
            engine_hold <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!engine_busy && (idle_cnt_r == HOLD_LAST)) begin
            // Commit the already-validated staging set; a coincident
            // update is captured afterwards and starts a fresh check.
            shd_r        <= stg_r;
            shd_valid    <= 1'b1;
            commit_pulse <= 1'b1;
            if (update_cnt != '1) begin
              update_cnt <= update_cnt + CNT_W'(1);
            end else begin
              update_cnt <= update_cnt;
            end
            engine_hold <= 1'b0;
            idle_cnt_r  <= 8'd0;
            if (params_update) begin
              stg_r   <= live_s;
              state_r <= ST_CHECK;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (params_update) begin
            // Retrigger: hold stays asserted while the new set is checked.
            stg_r      <= live_s;
            idle_cnt_r <= 8'd0;
            state_r    <= ST_CHECK;
          end else if (engine_busy) begin
            idle_cnt_r <= 8'd0;
          end else begin
            idle_cnt_r <= idle_cnt_r + 8'd1;
          end
        end
        default: begin
          engine_hold <= 1'b0;
          idle_cnt_r  <= 8'd0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef PARAMS_CHECK_EN
  assign err_cfg = 1'b0;
`endif

  assign shd_bwt_len     = shd_r.bwt_len;
  assign shd_pri_pos     = shd_r.pri_pos;
  assign shd_acc_cnt_A   = shd_r.acc_cnt_A;
  assign shd_acc_cnt_C   = shd_r.acc_cnt_C;
  assign shd_acc_cnt_G   = shd_r.acc_cnt_G;
  assign shd_acc_cnt_T   = shd_r.acc_cnt_T;
  assign shd_min_mlen    = shd_r.min_mlen;
  assign shd_sf_mlen     = shd_r.sf_mlen;
  assign shd_rs_min_mlen = shd_r.rs_min_mlen;
  assign shd_sf_max_intv = shd_r.sf_max_intv;
  assign shd_rs_max_intv = shd_r.rs_max_intv;

endmodule

// File: tb/tb_bwt_params_shadow.sv
// Testbench for bwt_params_shadow: directed scenarios with a timestamp-based
// reference model compared every cycle, plus hand-computed literal checks.
module tb_bwt_params_shadow;
  localparam int IH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic params_update = 1'b0;
  logic engine_busy = 1'b0;
  logic [39:0] bwt_len = '0, pri_pos = '0, acc_a = '0, acc_c = '0, acc_g = '0, acc_t = '0;
  logic [15:0] min_mlen = '0, sf_mlen = '0, rs_min_mlen = '0;
  logic [39:0] sf_max_intv = '0, rs_max_intv = '0;

  always #5 clk = ~clk;

  logic        engine_hold, shd_valid, commit_pulse, err_cfg;
  logic [39:0] s_len, s_pri, s_a, s_c, s_g, s_t, s_sfmax, s_rsmax;
  logic [15:0] s_min, s_sfm, s_rsm;
  logic [15:0] update_cnt;

  logic        d2_hold, d2_valid, d2_pulse, d2_err;
  logic [39:0] d2_len, d2_pri, d2_a, d2_c, d2_g, d2_t, d2_sfmax, d2_rsmax;
  logic [15:0] d2_min, d2_sfm, d2_rsm;
  logic [1:0]  d2_cnt;

  bwt_params_shadow #(.IDLE_HOLD(IH), .CNT_W(16)) dut (
    .s_axi_aclk(clk), .rst(rst), .params_update(params_update),
    .bwt_len(bwt_len), .pri_pos(pri_pos),
    .acc_cnt_A(acc_a), .acc_cnt_C(acc_c), .acc_cnt_G(acc_g), .acc_cnt_T(acc_t),
    .min_mlen(min_mlen), .sf_mlen(sf_mlen), .rs_min_mlen(rs_min_mlen),
    .sf_max_intv(sf_max_intv), .rs_max_intv(rs_max_intv),
    .engine_busy(engine_busy), .engine_hold(engine_hold),
    .shd_bwt_len(s_len), .shd_pri_pos(s_pri),
    .shd_acc_cnt_A(s_a), .shd_acc_cnt_C(s_c), .shd_acc_cnt_G(s_g), .shd_acc_cnt_T(s_t),
    .shd_min_mlen(s_min), .shd_sf_mlen(s_sfm), .shd_rs_min_mlen(s_rsm),
    .shd_sf_max_intv(s_sfmax), .shd_rs_max_intv(s_rsmax),
    .shd_valid(shd_valid), .commit_pulse(commit_pulse), .err_cfg(err_cfg),
    .update_cnt(update_cnt)
  );

  bwt_params_shadow #(.IDLE_HOLD(IH), .CNT_W(2)) dut2 (
    .s_axi_aclk(clk), .rst(rst), .params_update(params_update),
    .bwt_len(bwt_len), .pri_pos(pri_pos),
    .acc_cnt_A(acc_a), .acc_cnt_C(acc_c), .acc_cnt_G(acc_g), .acc_cnt_T(acc_t),
    .min_mlen(min_mlen), .sf_mlen(sf_mlen), .rs_min_mlen(rs_min_mlen),
    .sf_max_intv(sf_max_intv), .rs_max_intv(rs_max_intv),
    .engine_busy(engine_busy), .engine_hold(d2_hold),
    .shd_bwt_len(d2_len), .shd_pri_pos(d2_pri),
    .shd_acc_cnt_A(d2_a), .shd_acc_cnt_C(d2_c), .shd_acc_cnt_G(d2_g), .shd_acc_cnt_T(d2_t),
    .shd_min_mlen(d2_min), .shd_sf_mlen(d2_sfm), .shd_rs_min_mlen(d2_rsm),
    .shd_sf_max_intv(d2_sfmax), .shd_rs_max_intv(d2_rsmax),
    .shd_valid(d2_valid), .commit_pulse(d2_pulse), .err_cfg(d2_err),
    .update_cnt(d2_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [367:0] act, input logic [367:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [367:0] live_vec();
    return {bwt_len, pri_pos, acc_a, acc_c, acc_g, acc_t, min_mlen, sf_mlen,
            rs_min_mlen, sf_max_intv, rs_max_intv};
  endfunction

  // Acceptance rule for a captured set, stated directly on the field values.
  function automatic bit cfg_ok(input logic [367:0] v);
`ifdef PARAMS_CHECK_EN
    logic [39:0] len, pri, a, c, g, t;
    logic [15:0] mn;
    len = v[367:328]; pri = v[327:288]; a = v[287:248]; c = v[247:208];
    g = v[207:168]; t = v[167:128]; mn = v[127:112];
    return (a <= c) && (c <= g) && (g <= t) && (t <= len) && (pri <= len) && (mn != 16'd0);
`else
    return (v === v);
`endif
  endfunction

  // Reference model: a pending capture commits once the engine has shown
  // IH consecutive idle cycles, counted from the first cycle after the
  // one-cycle check; tracked with cycle timestamps.
  int cyc = 0;
  bit m_init = 0;
  bit m_have = 0, m_hold = 0, m_valid = 0, m_pulse = 0, m_err = 0;
  int m_cap = 0, m_quiet = 0, m_cnt = 0, m_cnt2 = 0;
  logic [367:0] m_pend = '0, m_shd = '0;

  // Advance the model by one clock, reading the inputs of the ending cycle.
  always @(posedge clk) begin
    int c;
    bit drained;
    c = cyc;
    if (rst) begin
      m_init = 1; m_have = 0; m_hold = 0; m_valid = 0; m_pulse = 0; m_err = 0;
      m_cnt = 0; m_cnt2 = 0; m_pend = '0; m_shd = '0;
    end else begin
      m_pulse = 0;
      drained = m_have && (c >= m_cap + 2) && !engine_busy && (c - m_quiet + 1 >= IH);
      if (drained) begin
        m_shd = m_pend; m_valid = 1; m_pulse = 1; m_have = 0; m_hold = 0;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end else if (m_have && !params_update) begin
        if (c == m_cap + 1) begin
          if (cfg_ok(m_pend)) begin m_hold = 1; m_quiet = c + 1; end
          else begin m_err = 1; m_have = 0; m_hold = 0; end
        end else if (engine_busy) begin
          m_quiet = c + 1;
        end
      end
      if (params_update) begin
        m_pend = live_vec(); m_cap = c; m_have = 1;
      end
    end
    cyc = c + 1;
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("commit_pulse", commit_pulse, m_pulse);
      chk("engine_hold", engine_hold, m_hold);
      chk("shd_valid", shd_valid, m_valid);
      chk("err_cfg", err_cfg, m_err);
      chk("update_cnt", update_cnt, m_cnt[15:0]);
      chk("shd_set", {s_len, s_pri, s_a, s_c, s_g, s_t, s_min, s_sfm, s_rsm, s_sfmax, s_rsmax}, m_shd);
      chk("d2_update_cnt", d2_cnt, m_cnt2[1:0]);
      chk("d2_commit_pulse", d2_pulse, m_pulse);
    end
  end

  int b = 0;

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_at(input int c);
    at(c);
    params_update = 1'b1;
    at(c + 1);
    params_update = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    params_update = 1'b0; engine_busy = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    b = cyc;
  endtask

  task automatic set_live1();
    bwt_len = 40'h12_3456_789A; pri_pos = 40'h5;
    acc_a = 40'h10; acc_c = 40'h20; acc_g = 40'h30; acc_t = 40'h40;
    min_mlen = 16'd19; sf_mlen = 16'd20; rs_min_mlen = 16'd21;
    sf_max_intv = 40'h100; rs_max_intv = 40'h200;
  endtask

  initial begin
    // Commit path with an idle engine.
    do_reset();
    chk("rst_update_cnt", update_cnt, 16'd0);
    chk("rst_shd_valid", shd_valid, 1'b0);
    chk("rst_engine_hold", engine_hold, 1'b0);
    set_live1();
    pulse_at(b + 10);
    chk("s1_hold_c11", engine_hold, 1'b0);
    at(b + 12); chk("s1_hold_c12", engine_hold, 1'b1);
    at(b + 15); chk("s1_hold_c15", engine_hold, 1'b1); chk("s1_pulse_c15", commit_pulse, 1'b0);
    at(b + 16);
    chk("s1_pulse_c16", commit_pulse, 1'b1);
    chk("s1_shd_len", s_len, 40'h12_3456_789A);
    chk("s1_valid", shd_valid, 1'b1);
    chk("s1_cnt", update_cnt, 16'd1);
    chk("s1_hold_c16", engine_hold, 1'b0);
    at(b + 17); chk("s1_pulse_c17", commit_pulse, 1'b0);

    // Busy engine delays the commit; live changes during drain are ignored.
    do_reset();
    set_live1();
    pulse_at(b + 10);
    at(b + 12); engine_busy = 1'b1;
    at(b + 14); bwt_len = 40'hAA;
    at(b + 21); engine_busy = 1'b0;
    at(b + 24); chk("s2_hold_c24", engine_hold, 1'b1); chk("s2_pulse_c24", commit_pulse, 1'b0);
    at(b + 25); chk("s2_pulse_c25", commit_pulse, 1'b1); chk("s2_shd_len", s_len, 40'h12_3456_789A);

    // Retrigger during drain: latest values win, a single commit.
    do_reset();
    set_live1();
    pulse_at(b + 10);
    at(b + 13); bwt_len = 40'h100;
    pulse_at(b + 13);
    chk("s3_hold_c14", engine_hold, 1'b1);
    at(b + 16); chk("s3_pulse_c16", commit_pulse, 1'b0);
    at(b + 19);
    chk("s3_pulse_c19", commit_pulse, 1'b1);
    chk("s3_shd_len", s_len, 40'h100);
    chk("s3_cnt", update_cnt, 16'd1);

    // Out-of-order accumulated counts.
    do_reset();
    set_live1();
    acc_c = 40'h5;
    pulse_at(b + 10);
`ifdef PARAMS_CHECK_EN
    at(b + 12); chk("s4_err", err_cfg, 1'b1); chk("s4_hold", engine_hold, 1'b0);
    at(b + 16); chk("s4_pulse", commit_pulse, 1'b0); chk("s4_valid", shd_valid, 1'b0);
    chk("s4_shd_len", s_len, 40'h0);
`else
    at(b + 16); chk("s4_pulse", commit_pulse, 1'b1); chk("s4_err", err_cfg, 1'b0);
    chk("s4_shd_c", s_c, 40'h5);
`endif

    // Reset in the middle of a drain discards the pending set.
    do_reset();
    set_live1();
    pulse_at(b + 10);
    at(b + 13); rst = 1'b1;
    at(b + 14); rst = 1'b0;
    chk("s5_hold_c14", engine_hold, 1'b0);
    at(b + 16); chk("s5_pulse", commit_pulse, 1'b0); chk("s5_valid", shd_valid, 1'b0);
    chk("s5_shd_len", s_len, 40'h0);
    pulse_at(b + 20);
    at(b + 26); chk("s5_pulse_late", commit_pulse, 1'b1); chk("s5_shd_len_late", s_len, 40'h12_3456_789A);

    // Back-to-back updates landing on commit edges; counter saturation.
    do_reset();
    set_live1();
    for (int i = 0; i < 5; i++) begin
      bwt_len = 40'h1000 + 40'(i);
      pulse_at(b + 10 + 5 * i);
      if (i == 1) begin
        chk("s6_pulse_c16", commit_pulse, 1'b1);
        chk("s6_hold_c16", engine_hold, 1'b0);
        chk("s6_shd_len_c16", s_len, 40'h1000);
      end
    end
    at(b + 36); chk("s6_pulse_c36", commit_pulse, 1'b1); chk("s6_shd_len_c36", s_len, 40'h1004);
    at(b + 37);
    chk("s6_cnt16", update_cnt, 16'd5);
    chk("s6_cnt2_sat", d2_cnt, 2'd3);

    at(b + 45);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
